// File: rtl/keypad_pkg.sv
// Shared types and legacy 4x4 key layout for the keypad scanner.
// Holds the FSM state enum, sign-class codes and the code-to-key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESENT,
    ST_RELEASE
  } state_e;

  localparam logic [2:0] SIGN_NONE  = 3'b000;
  localparam logic [2:0] SIGN_MINUS = 3'b100;
  localparam logic [2:0] SIGN_PLUS  = 3'b010;
  localparam logic [2:0] SIGN_A     = 3'b001;
  localparam logic [2:0] SIGN_BC    = 3'b011;
  localparam logic [2:0] SIGN_EQ    = 3'b111;

  localparam logic [3:0] VAL_A    = 4'hA;
  localparam logic [3:0] VAL_B    = 4'hB;
  localparam logic [3:0] VAL_C    = 4'hC;
  localparam logic [3:0] VAL_D    = 4'hD;
  localparam logic [3:0] VAL_STAR = 4'hE;
  localparam logic [3:0] VAL_HASH = 4'hF;

  typedef struct packed {
    logic [3:0] value;
    logic [2:0] sign;
  } key_map_t;

  // code = col_idx*4 + row_idx on the legacy 4x4 pad
  function automatic key_map_t key_map(
    input logic [3:0] code
  );
    key_map_t m;
    m.value = 4'h0;
    m.sign  = SIGN_NONE;
    case (code)
      4'd0:  m = '{VAL_A, SIGN_A};
      4'd1:  m = '{VAL_B, SIGN_BC};
      4'd2:  m = '{VAL_C, SIGN_BC};
      4'd3:  m = '{VAL_D, SIGN_EQ};
      4'd4:  m = '{4'd3, SIGN_NONE};
      4'd5:  m = '{4'd6, SIGN_NONE};
      4'd6:  m = '{4'd9, SIGN_NONE};
      4'd7:  m = '{VAL_HASH, SIGN_PLUS};
      4'd8:  m = '{4'd2, SIGN_NONE};
      4'd9:  m = '{4'd5, SIGN_NONE};
      4'd10: m = '{4'd8, SIGN_NONE};
      4'd11: m = '{4'd0, SIGN_NONE};
      4'd12: m = '{4'd1, SIGN_NONE};
      4'd13: m = '{4'd4, SIGN_NONE};
      4'd14: m = '{4'd7, SIGN_NONE};
      4'd15: m = '{VAL_STAR, SIGN_MINUS};
      default: m = '{4'h0, SIGN_NONE};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/keypad_debounce_counter.sv
// Saturating consecutive-match counter with synchronous clear.
// Ports: clk, rst, clr (zero next), inc (count up), cnt (current count).
module keypad_debounce_counter #(
  parameter  int MAX = 4,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && cnt_q != W'(MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// Matrix keypad scanner: one-hot column strobe, debounced press/release.
// Ports: slow_clk, rst, row_in -> col_out, key_valid/key_ready/key_code, key_held, multi_key_err.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter  int N_ROWS          = 4,
  parameter  int N_COLS          = 4,
  parameter  int DEBOUNCE_CYCLES = 4,
  parameter  int SCAN_DWELL      = 1,
  localparam int CODE_W          = $clog2(N_ROWS * N_COLS)
) (
  input  logic              slow_clk,
  input  logic              rst,
  input  logic [N_ROWS-1:0] row_in,
  output logic [N_COLS-1:0] col_out,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CODE_W-1:0] key_code,
  output logic              key_held,
  output logic              multi_key_err
);

  localparam int RW = $clog2(N_ROWS);
  localparam int CW = $clog2(N_COLS);
  localparam int DW = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
  localparam int NW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [N_COLS-1:0] COL0 = {1'b1, {(N_COLS-1){1'b0}}};
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
  localparam logic [NW-1:0] CNT_LAST = NW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(N_COLS - 1);

  state_e            state_q, state_d;
  logic [N_COLS-1:0] col_q, col_d;
  logic [CW-1:0]     col_idx_q, col_idx_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [N_ROWS-1:0] pat_q, pat_d;
  logic [RW-1:0]     row_idx_q, row_idx_d;
  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              held_q, held_d;
  logic              err_q, err_d;

  logic              cnt_clr;
  logic              cnt_inc;
  logic [NW-1:0]     cnt;

  logic [RW-1:0]     hit_row;
  logic [N_COLS-1:0] col_rot;
  logic [CW-1:0]     col_idx_rot;

  keypad_debounce_counter #(
    .MAX (DEBOUNCE_CYCLES)
  ) u_cnt (
    .clk (slow_clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt)
  );

  // Bit N_ROWS-1 is row 0; only meaningful when row_in is one-hot.
  always_comb begin
    hit_row = '0;
    for (int b = 0; b < N_ROWS; b++) begin
      if (row_in[b]) hit_row = RW'(N_ROWS - 1 - b);
    end
  end

  // Column 0 sits on the MSB, so advancing shifts right and wraps to MSB.
  assign col_rot = col_q[0] ? COL0 : {1'b0, col_q[N_COLS-1:1]};
  assign col_idx_rot = (col_idx_q == COL_LAST) ? '0 : col_idx_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    col_idx_d = col_idx_q;
    dwell_d   = dwell_q;
    pat_d     = pat_q;
    row_idx_d = row_idx_q;
    valid_d   = valid_q;
    code_d    = code_q;
    held_d    = held_q;
    err_d     = 1'b0;
    cnt_clr   = 1'b1;
    cnt_inc   = 1'b0;
    unique case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if ($onehot(row_in)) begin
            pat_d     = row_in;
            row_idx_d = hit_row;
            state_d   = ST_DEBOUNCE;
          end else begin
            err_d     = !$onehot0(row_in);
            col_d     = col_rot;
            col_idx_d = col_idx_rot;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (row_in == pat_q) begin
          cnt_clr = 1'b0;
          cnt_inc = 1'b1;
          if (cnt == CNT_LAST) begin
            state_d = ST_PRESENT;
            valid_d = 1'b1;
            held_d  = 1'b1;
            code_d  = CODE_W'(int'(col_idx_q) * N_ROWS
                              + int'(row_idx_q));
          end
        end else begin
          state_d   = ST_SCAN;
          col_d     = col_rot;
          col_idx_d = col_idx_rot;
        end
      end
      ST_PRESENT: begin
        if (key_ready) begin
          valid_d = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (row_in == '0) begin
          cnt_clr = 1'b0;
          cnt_inc = 1'b1;
          if (cnt == CNT_LAST) begin
            state_d   = ST_SCAN;
            held_d    = 1'b0;
            col_d     = col_rot;
            col_idx_d = col_idx_rot;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge slow_clk) begin
    if (rst) begin
      state_q   <= ST_SCAN;
      col_q     <= COL0;
      col_idx_q <= '0;
      dwell_q   <= '0;
      pat_q     <= '0;
      row_idx_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      held_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      col_idx_q <= col_idx_d;
      dwell_q   <= dwell_d;
      pat_q     <= pat_d;
      row_idx_q <= row_idx_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      held_q    <= held_d;
      err_q     <= err_d;
    end
  end

  assign col_out       = col_q;
  assign key_valid     = valid_q;
  assign key_code      = code_q;
  assign key_held      = held_q;
  assign multi_key_err = err_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: default 4x4 instance and a 3x5 dwell-3 instance.
// Vector table for scan/reset/multi-key plus directed press sequences.
module tb_keypad_scan_debounce;
  import keypad_pkg::*;

  logic slow_clk = 1'b0;
  always #5 slow_clk = ~slow_clk;

  logic       rst_a = 1'b1;
  logic [3:0] row_a = '0;
  logic [3:0] col_a;
  logic       valid_a;
  logic       ready_a = 1'b0;
  logic [3:0] code_a;
  logic       held_a;
  logic       err_a;

  logic       rst_b = 1'b1;
  logic [2:0] row_b = '0;
  logic [4:0] col_b;
  logic       valid_b;
  logic       ready_b = 1'b0;
  logic [3:0] code_b;
  logic       held_b;
  logic       err_b;

  keypad_scan_debounce u_dut_a (
    .slow_clk      (slow_clk),
    .rst           (rst_a),
    .row_in        (row_a),
    .col_out       (col_a),
    .key_valid     (valid_a),
    .key_ready     (ready_a),
    .key_code      (code_a),
    .key_held      (held_a),
    .multi_key_err (err_a)
  );

  keypad_scan_debounce #(
    .N_ROWS          (3),
    .N_COLS          (5),
    .DEBOUNCE_CYCLES (4),
    .SCAN_DWELL      (3)
  ) u_dut_b (
    .slow_clk      (slow_clk),
    .rst           (rst_b),
    .row_in        (row_b),
    .col_out       (col_b),
    .key_valid     (valid_b),
    .key_ready     (ready_b),
    .key_code      (code_b),
    .key_held      (held_b),
    .multi_key_err (err_b)
  );

  int total = 0;
  int bad   = 0;
  int exp_a[$];
  int exp_b[$];

  typedef struct {
    logic       rst;
    logic [3:0] row;
    logic       ready;
    logic [3:0] col;
    logic       valid;
    logic       held;
    logic       err;
    logic [3:0] code;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clk);
    #1;
  endtask

  task automatic wait_col_a(input logic [3:0] c);
    int n = 0;
    while (col_a !== c && n < 40) begin
      tick();
      n++;
    end
    chk("wait_col_a", col_a, c);
  endtask

  task automatic wait_col_b(input logic [4:0] c);
    int n = 0;
    while (col_b !== c && n < 60) begin
      tick();
      n++;
    end
    chk("wait_col_b", col_b, c);
  endtask

  // Transfers happen on the next rising edge; check them mid-cycle.
  always @(negedge slow_clk) begin
    if (valid_a === 1'b1 && ready_a === 1'b1) begin
      total++;
      if (exp_a.size() == 0) begin
        bad++;
        $display("FAIL sb_a: unexpected event code=%0d", code_a);
      end else begin
        int e;
        e = exp_a.pop_front();
        if (code_a !== 4'(e)) begin
          bad++;
          $display("FAIL sb_a: got code %0d want %0d", code_a, e);
        end
      end
    end
    if (valid_b === 1'b1 && ready_b === 1'b1) begin
      total++;
      if (exp_b.size() == 0) begin
        bad++;
        $display("FAIL sb_b: unexpected event code=%0d", code_b);
      end else begin
        int e;
        e = exp_b.pop_front();
        if (code_b !== 4'(e)) begin
          bad++;
          $display("FAIL sb_b: got code %0d want %0d", code_b, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    key_map_t km;
    //        rst   row      rdy   col      vld   held  err   code
    vt[0]  = '{1'b1, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[1]  = '{1'b1, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[2]  = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[5]  = '{1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[6]  = '{1'b0, 4'b1100, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b1, 4'd0};
    vt[7]  = '{1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[8]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[9]  = '{1'b0, 4'b0111, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 4'd0};
    vt[10] = '{1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'd0};

    for (int i = 0; i < 11; i++) begin
      rst_a   = vt[i].rst;
      row_a   = vt[i].row;
      ready_a = vt[i].ready;
      tick();
      chk($sformatf("v%0d.col", i), col_a, vt[i].col);
      chk($sformatf("v%0d.valid", i), valid_a, vt[i].valid);
      chk($sformatf("v%0d.held", i), held_a, vt[i].held);
      chk($sformatf("v%0d.err", i), err_a, vt[i].err);
      chk($sformatf("v%0d.code", i), code_a, vt[i].code);
    end
    ready_a = 1'b0;

    // Press "5" (col 2, row 1)
    wait_col_a(4'b0010);
    row_a = 4'b0100;
    exp_a.push_back(9);
    tick();
    chk("p5.frozen", col_a, 4'b0010);
    chk("p5.det_valid", valid_a, 0);
    repeat (3) tick();
    chk("p5.early", valid_a, 0);
    tick();
    chk("p5.valid", valid_a, 1);
    chk("p5.code", code_a, 9);
    chk("p5.held", held_a, 1);
    chk("p5.col", col_a, 4'b0010);
    tick();
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    row_a = 4'b0000;
    chk("p5.acc_valid", valid_a, 0);
    chk("p5.acc_held", held_a, 1);
    repeat (3) tick();
    chk("p5.rel_held", held_a, 1);
    chk("p5.rel_col", col_a, 4'b0010);
    tick();
    chk("p5.resume", col_a, 4'b0001);
    chk("p5.unheld", held_a, 0);

    // Bounce on "D" (col 0, row 3)
    wait_col_a(4'b1000);
    row_a = 4'b0001;
    tick();
    chk("bd.frozen", col_a, 4'b1000);
    tick();
    row_a = 4'b0000;
    tick();
    chk("bd.resume", col_a, 4'b0100);
    chk("bd.valid", valid_a, 0);
    chk("bd.err", err_a, 0);
    repeat (8) tick();
    chk("bd.novalid", valid_a, 0);
    wait_col_a(4'b1000);
    row_a = 4'b0001;
    exp_a.push_back(3);
    tick();
    repeat (3) tick();
    chk("d.early", valid_a, 0);
    tick();
    chk("d.valid", valid_a, 1);
    chk("d.code", code_a, 3);
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    row_a = 4'b0000;
    repeat (4) tick();
    chk("d.resume", col_a, 4'b0100);
    chk("d.unheld", held_a, 0);

    // Backpressure on "*" (col 3, row 3), key released early
    wait_col_a(4'b0001);
    row_a = 4'b0001;
    exp_a.push_back(15);
    tick();
    repeat (4) tick();
    chk("st.valid", valid_a, 1);
    row_a = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("st.hold%0d.v", i), valid_a, 1);
      chk($sformatf("st.hold%0d.c", i), code_a, 15);
    end
    ready_a = 1'b1;
    tick();
    chk("st.acc_valid", valid_a, 0);
    repeat (4) tick();
    chk("st.resume", col_a, 4'b1000);
    chk("st.unheld", held_a, 0);
    repeat (6) tick();
    chk("st.once", valid_a, 0);
    ready_a = 1'b0;

    // Reset while an event is pending on "1" (col 3, row 0)
    wait_col_a(4'b0001);
    row_a = 4'b1000;
    exp_a.push_back(12);
    tick();
    repeat (4) tick();
    chk("rp.valid", valid_a, 1);
    chk("rp.code", code_a, 12);
    rst_a = 1'b1;
    tick();
    exp_a.delete();
    chk("rp.rst_valid", valid_a, 0);
    chk("rp.rst_col", col_a, 4'b1000);
    chk("rp.rst_held", held_a, 0);
    chk("rp.rst_code", code_a, 0);
    rst_a = 1'b0;
    row_a = 4'b0000;
    tick();
    chk("rp.restart", col_a, 4'b0100);

    // 3x5 instance, dwell 3
    tick();
    chk("b.rst_col", col_b, 5'b10000);
    chk("b.rst_valid", valid_b, 0);
    rst_b = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      logic [4:0] ec;
      ec = 5'b10000 >> ((t / 3) % 5);
      tick();
      chk($sformatf("b.dwell%0d", t), col_b, ec);
    end
    wait_col_b(5'b00001);
    row_b = 3'b001;
    exp_b.push_back(14);
    repeat (3) tick();
    chk("b.frozen", col_b, 5'b00001);
    chk("b.det_valid", valid_b, 0);
    repeat (3) tick();
    chk("b.early", valid_b, 0);
    tick();
    chk("b.valid", valid_b, 1);
    chk("b.code", code_b, 14);
    chk("b.held", held_b, 1);
    ready_b = 1'b1;
    tick();
    ready_b = 1'b0;
    row_b = 3'b000;
    chk("b.acc_valid", valid_b, 0);
    repeat (4) tick();
    chk("b.resume", col_b, 5'b10000);
    chk("b.unheld", held_b, 0);

    // Legacy layout map
    km = key_map(4'd9);
    chk("map5.val", km.value, 5);
    chk("map5.sign", km.sign, 3'b000);
    km = key_map(4'd15);
    chk("mapstar.sign", km.sign, 3'b100);
    km = key_map(4'd3);
    chk("mapD.sign", km.sign, 3'b111);

    chk("sb_a.empty", exp_a.size(), 0);
    chk("sb_b.empty", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
